// File: rtl/apu_mixer.sv
// apu_mixer: four-channel stereo mixer with master volume, PCM and PDM outputs.
//
// Every SAMPLE_DIV cycles a sample FSM captures the channel DAC codes, the
// DAC enables, the NR51 pan bits and the NR50 volumes. It then sums the
// bipolar channel levels into a left and a right accumulator, scales each
// sum by (vol+1), and presents the result on the registered PCM outputs
// together with a one-cycle pcm_valid pulse. A first-order sigma-delta
// modulator per side turns the held PCM value into a PDM bitstream.
//
// Ports:
//   apuv_4mhz            clock, rising edge
//   napu_reset           synchronous active-low reset
//   apu_on               master enable; low silences outputs and holds the divider
//   ch1..ch4_code[3:0]   channel DAC codes
//   dac_en[3:0]          per-channel DAC enable (bit n = channel n+1)
//   lmixer/rmixer[3:0]   left/right pan enables (bit n = channel n+1)
//   lvol/rvol[2:0]       master volume per side
//   left_pcm/right_pcm   signed OUT_W-bit samples
//   pcm_valid            one-cycle strobe when new samples are presented
//   left_pdm/right_pdm   sigma-delta bitstreams
module apu_mixer #(
    parameter int SAMPLE_DIV = 32,
    parameter int OUT_W      = 10
) (
    input  logic             apuv_4mhz,
    input  logic             napu_reset,
    input  logic             apu_on,
    input  logic [3:0]       ch1_code,
    input  logic [3:0]       ch2_code,
    input  logic [3:0]       ch3_code,
    input  logic [3:0]       ch4_code,
    input  logic [3:0]       dac_en,
    input  logic [3:0]       lmixer,
    input  logic [3:0]       rmixer,
    input  logic [2:0]       lvol,
    input  logic [2:0]       rvol,
    output logic [OUT_W-1:0] left_pcm,
    output logic [OUT_W-1:0] right_pcm,
    output logic             pcm_valid,
    output logic             left_pdm,
    output logic             right_pdm
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAP, S_ACC1, S_ACC2, S_ACC3, S_ACC4, S_SCALE, S_OUT
    } state_t;

    // Bipolar DAC level: code 0..15 maps to -15..+15 in steps of 2.
    function automatic logic signed [6:0] dac_level(input logic [3:0] code,
                                                    input logic       en);
        logic signed [6:0] lvl;
        lvl = $signed({2'b00, code, 1'b0}) - 7'sd15;
        return en ? lvl : 7'sd0;
    endfunction

    // acc * (vol+1); |acc| <= 60 and vol+1 <= 8, so the product is exact.
    function automatic logic signed [OUT_W-1:0] scale_vol(input logic signed [6:0] acc,
                                                          input logic [2:0]        vol);
        logic signed [OUT_W-1:0] a;
        logic        [OUT_W-1:0] m;
        a = OUT_W'(acc);
        m = OUT_W'(vol) + OUT_W'(1);
        return a * $signed(m);
    endfunction

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_on;
    logic [15:0]           r_codes;
    logic [3:0]            r_en;
    logic [3:0]            r_lmix;
    logic [3:0]            r_rmix;
    logic [2:0]            r_lvol;
    logic [2:0]            r_rvol;
    logic signed [6:0]     r_lacc;
    logic signed [6:0]     r_racc;
    logic [9:0]            r_linteg;
    logic [9:0]            r_rinteg;

    logic                  w_strobe;
    logic [1:0]            w_idx;
    logic signed [6:0]     w_d;
    logic [9:0]            w_lu;
    logic [9:0]            w_ru;
    logic [10:0]           w_linteg_nx;
    logic [10:0]           w_rinteg_nx;

    assign w_strobe = r_on && (r_cnt == CNT_LAST);

    // Channel selected by the current accumulate state.
    always_comb begin
        w_idx = 2'd0;
        case (r_state)
            S_ACC2:  w_idx = 2'd1;
            S_ACC3:  w_idx = 2'd2;
            S_ACC4:  w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
        w_d = dac_level(r_codes[{w_idx, 2'b00} +: 4], r_en[w_idx]);
    end

    // r_on lags apu_on (and reset release) by one edge and holds the divider
    // at 0 for that edge, so the first strobe lands SAMPLE_DIV cycles after
    // the enable appears.
    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_on      <= 1'b0;
            r_codes   <= '0;
            r_en      <= '0;
            r_lmix    <= '0;
            r_rmix    <= '0;
            r_lvol    <= '0;
            r_rvol    <= '0;
            r_lacc    <= '0;
            r_racc    <= '0;
            left_pcm  <= '0;
            right_pcm <= '0;
            pcm_valid <= 1'b0;
        end else if (!apu_on) begin
            r_on      <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            left_pcm  <= '0;
            right_pcm <= '0;
            pcm_valid <= 1'b0;
        end else begin
            r_on      <= 1'b1;
            pcm_valid <= 1'b0;
            if (!r_on || r_cnt == CNT_LAST) r_cnt <= '0;
            else                             r_cnt <= r_cnt + 1'b1;

            case (r_state)
                S_IDLE: if (w_strobe) r_state <= S_CAP;
                // Capture stage: freeze all mixing inputs for this sample.
                S_CAP: begin
                    r_codes <= {ch4_code, ch3_code, ch2_code, ch1_code};
                    r_en    <= dac_en;
                    r_lmix  <= lmixer;
                    r_rmix  <= rmixer;
                    r_lvol  <= lvol;
                    r_rvol  <= rvol;
                    r_lacc  <= '0;
                    r_racc  <= '0;
                    r_state <= S_ACC1;
                end
                // Accumulate stages: one channel per cycle.
                S_ACC1, S_ACC2, S_ACC3, S_ACC4: begin
                    if (r_lmix[w_idx]) r_lacc <= r_lacc + w_d;
                    if (r_rmix[w_idx]) r_racc <= r_racc + w_d;
                    case (r_state)
                        S_ACC1:  r_state <= S_ACC2;
                        S_ACC2:  r_state <= S_ACC3;
                        S_ACC3:  r_state <= S_ACC4;
                        default: r_state <= S_SCALE;
                    endcase
                end
                // Scale stage: outputs and pcm_valid become visible in S_OUT.
                S_SCALE: begin
                    left_pcm  <= scale_vol(r_lacc, r_lvol);
                    right_pcm <= scale_vol(r_racc, r_rvol);
                    pcm_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Offset to unsigned 0..960; the low 10 bits suffice since |pcm| <= 480.
    assign w_lu        = left_pcm[9:0] + 10'd480;
    assign w_ru        = right_pcm[9:0] + 10'd480;
    assign w_linteg_nx = {1'b0, r_linteg} + {1'b0, w_lu};
    assign w_rinteg_nx = {1'b0, r_rinteg} + {1'b0, w_ru};

    // Sigma-delta stage: the integrator carry-out is the PDM bit.
    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset || !apu_on) begin
            r_linteg  <= '0;
            r_rinteg  <= '0;
            left_pdm  <= 1'b0;
            right_pdm <= 1'b0;
        end else begin
            r_linteg  <= w_linteg_nx[9:0];
            r_rinteg  <= w_rinteg_nx[9:0];
            left_pdm  <= w_linteg_nx[10];
            right_pdm <= w_rinteg_nx[10];
        end
    end

endmodule
